// File: rtl/pdm_serializer.sv
// pdm_serializer
//   Drives the board audio amplifier with a 1-bit PDM stream. Signed PCM words
//   arrive over a valid/ready handshake into a small FIFO; a first-order
//   sigma-delta modulator holds each word for OVERSAMPLE PDM bits.
// Ports
//   clock_i     system clock, all logic on posedge
//   reset_n_i   synchronous active-low reset
//   data_i      signed two's-complement PCM word
//   valid_i     data_i valid; transfer when valid_i && ready_o
//   ready_o     FIFO can accept a word
//   pdm_clk_o   PDM bit clock, 50% duty
//   pdm_data_o  PDM bit stream, updated with the falling edge of pdm_clk_o
//   audio_sd_o  amplifier enable (1 = on)
//   underrun_o  1-cycle pulse when a word slot starts with the FIFO empty
module pdm_serializer #(
  parameter int WORD_LENGTH      = 16,
  parameter int SYSTEM_FREQUENCY = 100000000,
  parameter int PDM_FREQUENCY    = 1000000,
  parameter int OVERSAMPLE       = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   pdm_clk_o,
  output logic                   pdm_data_o,
  output logic                   audio_sd_o,
  output logic                   underrun_o
);

  localparam int HALF = SYSTEM_FREQUENCY / (2 * PDM_FREQUENCY);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [WORD_LENGTH-1:0] div_count;
  logic [BW-1:0]          bit_count;
  logic [WORD_LENGTH-1:0] acc;
  logic [WORD_LENGTH-1:0] cur;

  logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [AW:0]            count_next;

  logic                   wrap;
  logic                   tick;
  logic                   slot_start;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [WORD_LENGTH-1:0] word;
  logic [WORD_LENGTH-1:0] off;
  logic [WORD_LENGTH:0]   sum;

  assign wrap       = (div_count == WORD_LENGTH'(HALF - 1));
  // A bit tick is the cycle where the registered bit clock goes 1 -> 0.
  assign tick       = wrap && pdm_clk_o;
  assign slot_start = tick && (bit_count == '0);
  assign empty      = (count == '0);
  // ready_o is already derived from the next-state count, so a push can never
  // hit a full FIFO.
  assign push       = valid_i && ready_o;
  assign pop        = slot_start && !empty;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    word = cur;
    if (slot_start) begin
      word = empty ? '0 : mem[rd_ptr];
    end
    off = {~word[WORD_LENGTH-1], word[WORD_LENGTH-2:0]};
    sum = {1'b0, acc} + {1'b0, off};
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      div_count  <= '0;
      pdm_clk_o  <= 1'b0;
    end else if (wrap) begin
      div_count  <= '0;
      pdm_clk_o  <= ~pdm_clk_o;
    end else begin
      div_count  <= div_count + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_next;
      ready_o <= (count_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      bit_count  <= '0;
      acc        <= '0;
      cur        <= '0;
      pdm_data_o <= 1'b0;
      underrun_o <= 1'b0;
      audio_sd_o <= 1'b0;
    end else begin
      audio_sd_o <= 1'b1;
      underrun_o <= slot_start && empty;
      if (tick) begin
        bit_count  <= (bit_count == BW'(OVERSAMPLE - 1)) ? '0 : bit_count + 1'b1;
        cur        <= word;
        acc        <= sum[WORD_LENGTH-1:0];
        pdm_data_o <= sum[WORD_LENGTH];
      end
    end
  end

endmodule
